// File: rtl/alu_issuer.sv
// alu_issuer: accepts one ALU request at a time, presents the operation to an
// external ALU for a single ISSUE cycle, waits WAIT_CYCLES clocks for the
// result and then holds the captured HI/LO until the consumer takes it.
// Optional feature: define ALU_ISSUER_DIVZERO_GUARD_EN to reject op 0101
// (divide) when operand B is zero instead of issuing it.
module alu_issuer #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  alu_select,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [63:0] alu_z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] wait_cnt, wait_cnt_n;
  logic [3:0] op_q;
  logic       accept;
  logic       issue_ok;
  logic       capture;
  logic       div_zero;
  logic       hi_op;

  // Codes 0000 and 1001 and 0100 have no ALU function and are rejected.
  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0100, 4'b1001: op_legal = 1'b0;
      default:                   op_legal = 1'b1;
    endcase
  endfunction

`ifdef ALU_ISSUER_DIVZERO_GUARD_EN
  assign div_zero = (req_op == 4'b0101) && (req_b == '0);
`else
  assign div_zero = 1'b0;
`endif

  // Multiply and divide produce a full 64-bit HI/LO result.
  assign hi_op = (op_q == 4'b0011) || (op_q == 4'b0101);

  // Next-state logic, wait counter and per-cycle strobes.
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    accept     = 1'b0;
    issue_ok   = 1'b0;
    capture    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (op_legal(req_op) && !div_zero) begin
            issue_ok = 1'b1;
            state_n  = ST_ISSUE;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        state_n    = ST_WAIT;
        wait_cnt_n = WAIT_LOAD;
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          capture = 1'b1;
          state_n = ST_DONE;
        end else begin
          wait_cnt_n = wait_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  // Handshake/status outputs are registered copies of the next-state decode,
  // so they line up exactly with the state they describe.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      alu_select <= '0;
    end else begin
      req_ready  <= (state_n == ST_IDLE);
      busy       <= (state_n != ST_IDLE);
      rsp_valid  <= (state_n == ST_DONE);
      alu_select <= issue_ok ? req_op : '0;
    end
  end

  // Operand latch and result capture.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      alu_a   <= '0;
      alu_b   <= '0;
      op_q    <= '0;
      rsp_hi  <= '0;
      rsp_lo  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (issue_ok) begin
        alu_a <= req_a;
        alu_b <= req_b;
        op_q  <= req_op;
      end
      if (accept) begin
        rsp_err <= !issue_ok;
      end
      if (capture) begin
        rsp_lo  <= alu_z[31:0];
        if (hi_op) begin
          rsp_hi <= alu_z[63:32];
        end
        rsp_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, ALU result latency in clocks after the issue cycle; legal range 1..15.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 clr  input  1  asynchronous active-high reset.
REQ-004 req_valid  input  1  operation request present.
REQ-005 req_ready  output  1  issuer accepts a request this cycle.
REQ-006 req_op  input  4  ALU select code.
REQ-007 req_a  input  32  operand A, signed.
REQ-008 req_b  input  32  operand B, signed.
REQ-009 alu_select  output  4  select driven to the ALU.
REQ-010 alu_a  output  32  operand A driven to the ALU.
REQ-011 alu_b  output  32  operand B driven to the ALU.
REQ-012 alu_z  input  64  ALU result, {HI[63:32], LO[31:0]}.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  consumer takes the result.
REQ-015 rsp_hi  output  32  captured HI register.
REQ-016 rsp_lo  output  32  captured LO register.
REQ-017 rsp_err  output  1  request rejected, no ALU operation performed.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-020 req_ready is high only in IDLE; a request is accepted when req_valid and req_ready are both high at a rising edge.
REQ-021 On acceptance of a legal op, latch req_op/req_a/req_b into alu_select/alu_a/alu_b and go to ISSUE.
REQ-022 Legal ops: 0001, 0010, 0011, 0101, 0110, 0111, 1000, 1010, 1011, 1100, 1101, 1110, 1111.
REQ-023 Illegal ops (0000, 0100, 1001): go directly to DONE with rsp_err=1, rsp_hi/rsp_lo unchanged, alu_select stays 0000.
REQ-024 alu_select is driven with the latched op only during ISSUE (exactly one cycle); in every other state it is 4'b0000 (ALU hold).
REQ-025 alu_a/alu_b hold the latched operands from ISSUE until the next acceptance.
REQ-026 ISSUE -> WAIT unconditionally; WAIT lasts WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded with WAIT_CYCLES-1 on entry.
REQ-027 At the last WAIT edge capture: ops 0011 and 0101 load rsp_hi<=alu_z[63:32] and rsp_lo<=alu_z[31:0]; all other legal ops load rsp_lo only, rsp_hi retained; rsp_err<=0; go to DONE.
REQ-028 DONE: rsp_valid=1; rsp_hi/rsp_lo/rsp_err stable until rsp_ready=1 at an edge, then -> IDLE, rsp_valid=0.
REQ-029 Back-to-back: rsp_ready in DONE and req_valid in the following IDLE cycle give a minimum period of WAIT_CYCLES+3 clocks per operation.
REQ-030 req_* inputs are ignored outside IDLE; a request held across DONE is accepted in the next IDLE cycle.

Reset
REQ-031 clr asserted at any time, including mid-ISSUE/WAIT, forces IDLE immediately, aborting the operation with no capture.
REQ-032 Reset values: req_ready=1 (once clr deasserts), rsp_valid=0, rsp_err=0, busy=0, alu_select=0000, alu_a=0, alu_b=0, rsp_hi=0, rsp_lo=0, wait counter=0.

Configuration
REQ-033 Macro ALU_ISSUER_DIVZERO_GUARD_EN: when defined, op 0101 with req_b==0 is treated as illegal per REQ-023 (rsp_err=1, no issue); when undefined it is issued normally and the ALU output is captured as-is.

Verification
REQ-034 Reset then op 0001, A=5, B=7, WAIT_CYCLES=1 -> alu_select=0001 for one cycle, rsp_valid after 3 clocks, rsp_lo=12, rsp_hi=0, rsp_err=0.
REQ-035 op 0011, A=0x10000, B=0x10000 -> rsp_hi=0x00000001, rsp_lo=0x00000000; following op 0110 A=0xFF, B=0x0F -> rsp_lo=0x0F, rsp_hi still 1.
REQ-036 op 0100 -> DONE next cycle with rsp_err=1, alu_select never leaves 0000, rsp_hi/rsp_lo unchanged.
REQ-037 op 0101, A=20, B=0: with macro -> rsp_err=1, no ALU issue; without macro -> alu_select=0101 issued, rsp_err=0.
REQ-038 rsp_ready held low 5 cycles in DONE -> rsp_valid and outputs stable, req_valid ignored; clr pulsed during WAIT -> IDLE, rsp_valid=0, outputs at reset values.
